cacheline_adapter: RTL and testbench
====================================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst, both inputs, 1 bit.
REQ-002 SHALL have the following parameters:
- LINE_W, 256, cacheline width
- BURST_W, 64, memory beat width
- BEATS, 4, LINE_W/BURST_W
REQ-003 SHALL have the following line-side ports:
- read_i, in, 1, line fill request from L1
- write_i, in, 1, line writeback request from L1
- address_i, in, 32, line request address
- line_i, in, 256, writeback line
- line_o, out, 256, filled line
- resp_o, out, 1, line transfer complete
REQ-004 SHALL have the following burst-side ports:
- read_o, out, 1, burst read request to memory
- write_o, out, 1, burst write request to memory
- address_o, out, 32, burst base address
- burst_i, in, 64, read beat data
- burst_o, out, 64, write beat data
- resp_i, in, 1, beat accepted or valid

Function
REQ-005 SHALL implement an FSM with states IDLE, READ, WRITE and DONE.
REQ-006 SHALL sample requests only in IDLE; write_i SHALL take priority when read_i and write_i are both high.
REQ-007 On the IDLE request edge, SHALL latch {address_i[31:5], 5'b0} into address_o, latch line_i (write only), clear the beat counter and enter READ or WRITE.
REQ-008 SHALL hold read_o high exactly while in READ and write_o high exactly while in WRITE; address_o SHALL stay constant for the whole burst.
REQ-009 In READ, each cycle with resp_i=1 SHALL store burst_i into beat[cnt] (beat 0 = line bits 63:0, ascending) and increment cnt.
REQ-010 In WRITE, burst_o SHALL equal latched line beat[cnt]; each resp_i=1 cycle SHALL increment cnt.
REQ-011 Cycles with resp_i=0 SHALL hold all state; there is no timeout.
REQ-012 cnt SHALL be 2 bits; on the resp_i edge with cnt=3 the FSM SHALL enter DONE and cnt SHALL wrap to 0.
REQ-013 In DONE, resp_o SHALL be high for exactly one cycle, with line_o valid (READ) and stable; the FSM SHALL then return to IDLE unconditionally.
REQ-014 line_o SHALL hold its last filled value until the next read fill.
REQ-015 resp_i in IDLE or DONE SHALL be ignored.
REQ-016 Minimum latency from request edge to resp_o SHALL be 5 cycles (4 back-to-back beats + DONE); the earliest next request is sampled the cycle after DONE.

Reset
REQ-017 rst=1 at any clk edge SHALL force IDLE, cnt=0, read_o=write_o=resp_o=0, address_o=0, line_o=0 and burst_o=0, abandoning any partial burst without a resp_o.
REQ-018 The first request after reset deassertion SHALL be sampled at the first edge with rst=0.

Structure
REQ-019 Package cache_pkg SHALL hold LINE_W, BURST_W, BEATS and the adapter state enum, shared with the L1 control.
REQ-020 The block SHALL be a single module with no sub-modules; the beat buffer is a 4x64 register array.

Verification
REQ-021 Read fill: read_i, address_i=0x0000_1234, with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220; line_o={44..,33..,22..,11..}; resp_o high for 1 cycle, 5 cycles after the request edge.
REQ-022 Writeback: write_i with line_i=0xAAAA...(beat3)..0x0001(beat0) and resp_i stalled 2 cycles before each beat -> burst_o presents beat0..beat3 in order, write_o is held, and a single resp_o follows.
REQ-023 Simultaneous read_i and write_i in IDLE -> WRITE is entered, write_o=1 and read_o=0.
REQ-024 rst asserted after the 2nd read beat -> next cycle read_o=0 and line_o=0; no resp_o; a following read completes normally with cnt starting at 0.
REQ-025 Spurious resp_i in IDLE, followed by a read -> no state change; the read's line_o excludes the spurious data.
REQ-026 Back-to-back read then write with read_i held through DONE -> exactly one idle cycle, then the new request starts and each transfer produces exactly one resp_o.

Source files
------------

// File: rtl/cacheline_adapter_pkg.sv
// Shared cacheline geometry and adapter state encoding for the L1 line/burst path.
package cache_pkg;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } adapter_state_t;
endpackage

// File: rtl/cacheline_adapter_if.sv
// Line-side (L1) and burst-side (memory) signals of the cacheline adapter.
interface cacheline_adapter_if;
    import cache_pkg::*;

    logic                read_i;
    logic                write_i;
    logic [ADDR_W-1:0]   address_i;
    logic [LINE_W-1:0]   line_i;
    logic [LINE_W-1:0]   line_o;
    logic                resp_o;

    logic                read_o;
    logic                write_o;
    logic [ADDR_W-1:0]   address_o;
    logic [BURST_W-1:0]  burst_i;
    logic [BURST_W-1:0]  burst_o;
    logic                resp_i;

    modport slave (
        input  read_i, write_i, address_i, line_i, burst_i, resp_i,
        output line_o, resp_o, read_o, write_o, address_o, burst_o
    );

    modport master (
        output read_i, write_i, address_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, read_o, write_o, address_o, burst_o
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits a 256-bit line fill/writeback into four 64-bit memory beats; resp_o pulses one cycle after the last beat
// (>= 5 cycles from request). Memory stalls by holding resp_i low; requests are only taken in IDLE.
module cacheline_adapter #(
    parameter int LINE_W  = cache_pkg::LINE_W,
    parameter int BURST_W = cache_pkg::BURST_W,
    parameter int BEATS   = cache_pkg::BEATS
) (
    input  logic               clk,
    input  logic               rst,
    cacheline_adapter_if.slave bus
);
    import cache_pkg::*;

    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [BURST_W-1:0] beat_q [BEATS];
    logic [BURST_W-1:0] beat_d [BEATS];
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               resp_q, resp_d;
    logic               fill_done;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^bus.address_i[OFF_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        line_d    = line_q;
        beat_d    = beat_q;
        read_d    = 1'b0;
        write_d   = 1'b0;
        resp_d    = 1'b0;
        fill_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.write_i || bus.read_i) begin
                    addr_d = {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d  = '0;
                end
                // Writeback wins a tie so dirty data is never lost behind a refill.
                if (bus.write_i) begin
                    state_d = ST_WRITE;
                    write_d = 1'b1;
                    for (int b = 0; b < BEATS; b++) begin
                        beat_d[b] = bus.line_i[b*BURST_W +: BURST_W];
                    end
                end else if (bus.read_i) begin
                    state_d = ST_READ;
                    read_d  = 1'b1;
                end
            end
            ST_READ: begin
                read_d = 1'b1;
                if (bus.resp_i) begin
                    beat_d[cnt_q] = bus.burst_i;
                    cnt_d         = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d   = ST_DONE;
                        read_d    = 1'b0;
                        resp_d    = 1'b1;
                        fill_done = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                write_d = 1'b1;
                if (bus.resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        write_d = 1'b0;
                        resp_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // line_o only moves on a completed fill, so L1 never sees a half-filled line.
        if (fill_done) begin
            for (int b = 0; b < BEATS; b++) begin
                line_d[b*BURST_W +: BURST_W] = beat_d[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
            for (int b = 0; b < BEATS; b++) begin
                beat_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;
    assign bus.address_o = addr_q;
    assign bus.line_o    = line_q;
    assign bus.burst_o   = write_q ? beat_q[cnt_q] : '0;
endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter with a transaction-level scoreboard.
module tb_cacheline_adapter;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    cacheline_adapter_if bus();

    cacheline_adapter #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W),
        .BEATS   (BEATS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                wr;
        bit                abort;
        logic [31:0]       addr;
        logic [LINE_W-1:0] line;
        int                resp_cyc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void chk(input string name, input logic [LINE_W-1:0] act,
                                input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One line transfer as the L1 and the memory would see it. stall<0 picks 0..2 stall cycles per beat.
    // abort_beat>=0 asserts rst once that many beats have been accepted.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [LINE_W-1:0] data,
                          input int stall, input bit also_rd, input bit hold_rd, input int abort_beat);
        int   st[BEATS];
        int   total;
        exp_t e;
        total = 0;
        for (int b = 0; b < BEATS; b++) begin
            st[b] = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            total += st[b];
        end
        e.wr       = wr;
        e.abort    = (abort_beat >= 0);
        e.addr     = {addr[31:5], 5'b0};
        e.line     = data;
        e.resp_cyc = cyc + 1 + BEATS + total;
        exp_q.push_back(e);

        bus.read_i    = !wr || also_rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = wr ? data : rand_line();
        step();
        bus.read_i    = hold_rd;
        bus.write_i   = 1'b0;
        bus.address_i = $urandom;
        bus.line_i    = rand_line();

        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_beat) begin
                bus.resp_i = 1'b0;
                bus.read_i = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            for (int s = 0; s < st[b]; s++) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = {$urandom, $urandom};
                step();
            end
            bus.resp_i  = 1'b1;
            bus.burst_i = wr ? {$urandom, $urandom} : data[b*BURST_W +: BURST_W];
            step();
        end
        bus.resp_i  = 1'b0;
        bus.burst_i = {$urandom, $urandom};
        step();
    endtask

    task automatic spurious(input int n);
        for (int i = 0; i < n; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            step();
        end
        bus.resp_i = 1'b0;
    endtask

    // Monitor: opens a transaction when a burst appears, follows its beats, closes it on resp_o.
    exp_t              cur;
    bit                active = 1'b0;
    int                beat_idx = 0;
    logic [LINE_W-1:0] mdl_line = '0;
    bit                rst_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_prev) begin
            if (active) chk("abandoned_txn_was_abort", LINE_W'(cur.abort), LINE_W'(1));
            active   = 1'b0;
            mdl_line = '0;
            chk("rst_read_o",    LINE_W'(bus.read_o),    '0);
            chk("rst_write_o",   LINE_W'(bus.write_o),   '0);
            chk("rst_resp_o",    LINE_W'(bus.resp_o),    '0);
            chk("rst_address_o", LINE_W'(bus.address_o), '0);
            chk("rst_burst_o",   LINE_W'(bus.burst_o),   '0);
            chk("rst_line_o",    bus.line_o,             mdl_line);
        end else begin
            if (!active && (bus.read_o || bus.write_o)) begin
                chk("burst_expected", LINE_W'(exp_q.size() > 0), LINE_W'(1));
                if (exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    active   = 1'b1;
                    beat_idx = 0;
                end
            end
            if (active && (bus.read_o || bus.write_o)) begin
                chk("write_o",   LINE_W'(bus.write_o),   LINE_W'(cur.wr));
                chk("read_o",    LINE_W'(bus.read_o),    LINE_W'(!cur.wr));
                chk("address_o", LINE_W'(bus.address_o), LINE_W'(cur.addr));
                chk("beat_overrun", LINE_W'(beat_idx < BEATS), LINE_W'(1));
                if (bus.write_o && beat_idx < BEATS)
                    chk("burst_o", LINE_W'(bus.burst_o), LINE_W'(cur.line[beat_idx*BURST_W +: BURST_W]));
                if (bus.resp_i) beat_idx++;
            end
            if (bus.resp_o) begin
                chk("resp_o_expected", LINE_W'(active), LINE_W'(1));
                if (active) begin
                    chk("resp_cycle", LINE_W'(cyc), LINE_W'(cur.resp_cyc));
                    chk("beat_count", LINE_W'(beat_idx), LINE_W'(BEATS));
                    chk("done_bursts_low", LINE_W'(bus.read_o | bus.write_o), '0);
                    if (!cur.wr) mdl_line = cur.line;
                    active = 1'b0;
                end
            end
            chk("line_o", bus.line_o, mdl_line);
        end
        rst_prev = rst;
    end

    localparam logic [LINE_W-1:0] FILL_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [LINE_W-1:0] WB_LINE   = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                                               64'h0F0F_0F0F_0F0F_0F0F, 64'h0000_0000_0000_0001};

    initial begin
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.address_i = '0;
        bus.line_i    = '0;
        bus.resp_i    = 1'b0;
        bus.burst_i   = '0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill taken on the first edge out of reset, back-to-back beats.
        do_txn(1'b0, 32'h0000_1234, FILL_LINE, 0, 1'b0, 1'b0, -1);
        // Writeback with two stall cycles ahead of every beat.
        do_txn(1'b1, 32'h0000_8040, WB_LINE, 2, 1'b0, 1'b0, -1);
        // Read and write requested together.
        do_txn(1'b1, 32'h0000_2000, rand_line(), 0, 1'b1, 1'b0, -1);
        // Memory responses while idle must not leak into the next fill.
        spurious(3);
        do_txn(1'b0, 32'h0000_3010, rand_line(), 1, 1'b0, 1'b0, -1);
        // Reset in the middle of a fill, then a clean fill.
        do_txn(1'b0, 32'h0000_4000, rand_line(), 0, 1'b0, 1'b0, 2);
        do_txn(1'b0, 32'h0000_5000, rand_line(), 0, 1'b0, 1'b0, -1);
        // Read with read_i held through DONE, immediately followed by a writeback.
        do_txn(1'b0, 32'h0000_6000, rand_line(), 0, 1'b0, 1'b1, -1);
        do_txn(1'b1, 32'h0000_7000, rand_line(), 0, 1'b1, 1'b0, -1);

        repeat (24) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, rand_line(), -1,
                   1'($urandom_range(0, 1)), 1'b0, -1);
        end

        repeat (4) step();
        chk("queue_drained", LINE_W'(exp_q.size()), '0);
        chk("txn_closed",    LINE_W'(active),       '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
